fifo_read_arbiter: RTL and testbench
====================================

Name: fifo_read_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit FIFO sink between N_SRC first-word-fall-through source FIFOs, e.g. SPI RX, FE RX and TDC.
- The sink is sram_fifo's FIFO_READ_NEXT_OUT / FIFO_EMPTY_IN / FIFO_DATA port.
- Grants one source at a time for a bounded burst, passes that source's data through, and optionally tags each word with the source ID.
- Sits between the receiver modules and the SRAM FIFO in the mmc3 top level.

Parameters:
- N_SRC, 4, number of source FIFOs (2..8).
- MAX_BURST, 16, maximum words popped per grant (1..256).
- TAG_EN, 1, when 1, overwrite DATA bits [31:28] with the granted source index.

Ports:
- BUS_CLK  in  1  single clock for all logic.
- RESET_N  in  1  asynchronous active-low reset.
- SRC_EMPTY  in  N_SRC  per-source FIFO empty flags.
- SRC_DATA  in  32*N_SRC  per-source head-of-FIFO words; source i occupies [32*i+:32].
- SRC_READ  out  N_SRC  per-source pop strobe.
- SRC_ENABLE  in  N_SRC  per-source arbitration enable mask.
- FIFO_READ_NEXT  in  1  sink pop strobe; acts only when FIFO_EMPTY=0.
- FIFO_EMPTY  out  1  sink-side empty flag.
- FIFO_DATA  out  32  sink-side word.
- GRANT_ID  out  3  index of the current or last granted source.
- BUSY  out  1  high while a grant is active.

Behaviour:
- Reset (async, RESET_N=0), all outputs:
  - state=IDLE, last_grant=N_SRC-1, burst_cnt=0, GRANT_ID=0.
  - BUSY=0, FIFO_EMPTY=1, SRC_READ=0, FIFO_DATA=0.
- Request vector: req[i] = ~SRC_EMPTY[i] & SRC_ENABLE[i].
- FSM IDLE:
  - If req≠0, select the first set bit scanning last_grant+1, last_grant+2, … modulo N_SRC.
  - Register the choice as grant and GRANT_ID, clear burst_cnt, go to GRANT.
  - Grant latency: 1 cycle from req asserting to FIFO_EMPTY falling.
- FSM GRANT, with granted source g:
  - Data path (combinational): FIFO_EMPTY = SRC_EMPTY[g]; FIFO_DATA = SRC_DATA[g], with [31:28]=g when TAG_EN=1.
  - Pop: SRC_READ[g] = FIFO_READ_NEXT & ~SRC_EMPTY[g]. All other SRC_READ bits stay 0. FIFO_READ_NEXT while FIFO_EMPTY=1 is ignored.
  - A pop increments burst_cnt (8-bit, saturating at MAX_BURST).
  - Release to IDLE at the clock edge when any of these hold:
    - (a) a pop occurs with burst_cnt==MAX_BURST-1;
    - (b) SRC_EMPTY[g]=1 and no pop this cycle;
    - (c) SRC_ENABLE[g]=0 (a pop in that same cycle still completes).
  - On release: last_grant=g.
- IDLE outputs: FIFO_EMPTY=1, SRC_READ=0, FIFO_DATA holds its last value (don't-care for the sink).
- Rotation:
  - A released source has lowest priority next round, even if it is still non-empty.
  - A single active source is re-granted after one IDLE cycle. Bubble cost: 1 cycle per burst.
- BUSY = (state==GRANT).
- GRANT_ID changes only on IDLE→GRANT.
- Source rules:
  - No word is popped from a source that is not granted.
  - No word is duplicated or dropped: each SRC_READ pulse equals exactly one accepted sink word.
- SRC_ENABLE changes in IDLE take effect the same cycle.
- Disabled sources are never granted.
- Reset mid-burst: immediate return to reset state. A pop strobe in the reset cycle is not forwarded.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - FSM state enum {IDLE, GRANT};
  - DATA_W=32, TAG_MSB=31, TAG_LSB=28;
  - function for the rotating priority search.
- One natural sub-module: rr_pick. It is a combinational rotating first-one finder with inputs req and last_grant, and outputs idx and valid. It is reusable by other basil arbiters.
- FSM, burst counter and data mux stay in the top.

Test Plan:
- Single source: SRC_EMPTY[1]=0 with 5 queued words, sink reads continuously, MAX_BURST=16 → IDLE→GRANT in 1 cycle, GRANT_ID=1, 5 words out with [31:28]=1. On empty: release, BUSY=0.
- Burst limit: sources 0 and 2 each hold 40 words, sink always reading, MAX_BURST=16 → sequence 16 from src0, 16 from src2, 16 from src0, 16 from src2, 8 from src0, 8 from src2. Exactly one IDLE cycle between bursts.
- Back-pressure: grant active, FIFO_READ_NEXT toggled 1-0-0-1 → SRC_READ mirrors only the 1 cycles, burst_cnt=2, no release.
- Enable drop: mid-burst on src3 with FIFO_READ_NEXT=1, SRC_ENABLE[3]→0 → that cycle's word is delivered, no further SRC_READ[3], next grant goes to the next enabled requester.
- Fairness/wrap: all 4 sources full, last_grant=3 → grant order 0,1,2,3,0. All sources disabled → FIFO_EMPTY stays 1 and BUSY stays 0.
- Async reset: assert RESET_N=0 mid-burst between clock edges → outputs reach reset values immediately. After release, arbitration restarts from source 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types, widths and rotating priority search for the FIFO read arbiter
package fifo_arb_pkg;

   typedef enum logic {IDLE, GRANT} state_t;

   localparam int DATA_W  = 32;
   localparam int TAG_MSB = 31;
   localparam int TAG_LSB = 28;

   // Returns {valid, idx} of the first request found scanning last+1, last+2, ... modulo n (n <= 8).
   // The scan runs from the farthest slot to the nearest so the nearest hit overwrites the result.
   function automatic logic [3:0] rr_first(input logic [7:0] req, input logic [2:0] last, input int n);
      logic [3:0] r;
      logic [2:0] k;
      r = '0;
      for (int i = 8; i >= 1; i--) begin
         k = 3'((int'(last) + i) % n);
         if (i <= n && req[k]) r = {1'b1, k};
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating first-one finder starting just after the last grant
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic [2:0]   last_grant,
   output logic [2:0]   idx,
   output logic         valid
);

   assign {valid, idx} = rr_first(8'(req), last_grant, N);

endmodule

// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter: round-robin burst arbiter sharing one FWFT sink between several source FIFOs
module fifo_read_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_SRC     = 4,
   parameter int MAX_BURST = 16,
   parameter bit TAG_EN    = 1
) (
   input  logic                      BUS_CLK,
   input  logic                      RESET_N,
   input  logic [N_SRC-1:0]          SRC_EMPTY,
   input  logic [DATA_W*N_SRC-1:0]   SRC_DATA,
   output logic [N_SRC-1:0]          SRC_READ,
   input  logic [N_SRC-1:0]          SRC_ENABLE,
   input  logic                      FIFO_READ_NEXT,
   output logic                      FIFO_EMPTY,
   output logic [DATA_W-1:0]         FIFO_DATA,
   output logic [2:0]                GRANT_ID,
   output logic                      BUSY
);

   localparam int         IW       = N_SRC > 1 ? $clog2(N_SRC) : 1;
   localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);
   localparam logic [7:0] SAT_CNT  = MAX_BURST > 255 ? 8'd255 : 8'(MAX_BURST);

   state_t            state_q, state_d;
   logic [2:0]        last_q, last_d, grant_q, grant_d;
   logic [7:0]        burst_q, burst_d;
   logic [DATA_W-1:0] data_q, data_d, word;
   logic [DATA_W-1:0] src_w [N_SRC];
   logic [N_SRC-1:0]  req;
   logic [IW-1:0]     g;
   logic [2:0]        pick_idx;
   logic              pick_valid, pop, release_g;

   for (genvar i = 0; i < N_SRC; i++) begin : g_src
      assign src_w[i] = SRC_DATA[DATA_W*i +: DATA_W];
   end

   assign g   = grant_q[IW-1:0];
   assign req = ~SRC_EMPTY & SRC_ENABLE;

   rr_pick #(.N(N_SRC)) u_pick (
      .req        (req),
      .last_grant (last_q),
      .idx        (pick_idx),
      .valid      (pick_valid)
   );

   assign BUSY       = state_q == GRANT;
   assign FIFO_EMPTY = BUSY ? SRC_EMPTY[g] : 1'b1;
   assign FIFO_DATA  = BUSY ? word : data_q;
   assign SRC_READ   = pop ? N_SRC'(1) << g : '0;
   assign GRANT_ID   = grant_q;

   // Data mux with optional source tag, pop strobe, burst accounting and grant/release decisions
   always_comb begin
      word = src_w[g];
      if (TAG_EN) word[TAG_MSB:TAG_LSB] = 4'(grant_q);
      pop       = BUSY & FIFO_READ_NEXT & ~SRC_EMPTY[g];
      release_g = (pop && burst_q == LAST_CNT) || (SRC_EMPTY[g] && !pop) || !SRC_ENABLE[g];
      state_d   = state_q;
      last_d    = last_q;
      grant_d   = grant_q;
      burst_d   = burst_q;
      data_d    = FIFO_DATA;
      if (!BUSY) begin
         if (pick_valid) begin
            state_d = GRANT;
            grant_d = pick_idx;
            burst_d = '0;
         end
      end else begin
         if (pop && burst_q != SAT_CNT) burst_d = burst_q + 8'd1;
         if (release_g) begin
            state_d = IDLE;
            last_d  = grant_q;
         end
      end
   end

   // State registers; reset makes the last grant the highest index so source 0 wins first
   always_ff @(posedge BUS_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         last_q  <= 3'(N_SRC - 1);
         grant_q <= '0;
         burst_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         burst_q <= burst_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// tb_fifo_read_arbiter: directed self-checking bench for the round-robin FIFO read arbiter
module tb_fifo_read_arbiter;

   logic         BUS_CLK = 1'b0;
   logic         RESET_N = 1'b0;
   logic [3:0]   SRC_EMPTY, SRC_READ;
   logic [3:0]   SRC_ENABLE = 4'hF;
   logic [127:0] SRC_DATA;
   logic         FIFO_READ_NEXT = 1'b0;
   logic         FIFO_EMPTY, BUSY;
   logic [31:0]  FIFO_DATA;
   logic [2:0]   GRANT_ID;

   int tot[4];
   int popped[4];
   int checks = 0;
   int failures = 0;
   int ev[$];
   int ps[$];
   logic [31:0] pd[$];
   int mon_s;

   fifo_read_arbiter #(.N_SRC(4), .MAX_BURST(16), .TAG_EN(1)) dut (
      .BUS_CLK        (BUS_CLK),
      .RESET_N        (RESET_N),
      .SRC_EMPTY      (SRC_EMPTY),
      .SRC_DATA       (SRC_DATA),
      .SRC_READ       (SRC_READ),
      .SRC_ENABLE     (SRC_ENABLE),
      .FIFO_READ_NEXT (FIFO_READ_NEXT),
      .FIFO_EMPTY     (FIFO_EMPTY),
      .FIFO_DATA      (FIFO_DATA),
      .GRANT_ID       (GRANT_ID),
      .BUSY           (BUSY)
   );

   always #5 BUS_CLK = ~BUS_CLK;

   for (genvar i = 0; i < 4; i++) begin : g_src
      assign SRC_EMPTY[i]         = tot[i] == popped[i];
      assign SRC_DATA[32*i +: 32] = {4'hC, 4'(i), 24'(popped[i])};
   end

   // Source FIFO model: each strobe pops one word from the addressed source
   always @(posedge BUS_CLK)
      for (int i = 0; i < 4; i++)
         if (SRC_READ[i] && tot[i] != popped[i]) popped[i] <= popped[i] + 1;

   // Per-cycle trace: 8 = idle, 9 = granted without pop, else popped source index
   always @(negedge BUS_CLK)
      if (RESET_N) begin
         mon_s = 9;
         for (int i = 0; i < 4; i++) if (SRC_READ[i]) mon_s = i;
         ev.push_back(BUSY ? mon_s : 8);
         if (SRC_READ != 4'b0) begin
            ps.push_back(mon_s);
            pd.push_back(FIFO_DATA);
         end
      end

   function automatic logic [31:0] exp_word(input int i, input int s);
      return {4'(i), 4'(i), 24'(s)};
   endfunction

   task automatic step;
      @(posedge BUS_CLK);
      #1;
   endtask

   task automatic do_reset;
      RESET_N = 1'b0;
      FIFO_READ_NEXT = 1'b0;
      SRC_ENABLE = 4'hF;
      for (int i = 0; i < 4; i++) tot[i] = popped[i];
      repeat (2) @(posedge BUS_CLK);
      #1 RESET_N = 1'b1;
      ev.delete();
      ps.delete();
      pd.delete();
   endtask

   task automatic test_reset;
      @(posedge BUS_CLK);
      #1;
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
      checks++; if (FIFO_EMPTY !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", FIFO_EMPTY); end
      checks++; if (SRC_READ !== 4'b0) begin failures++; $display("FAIL reset_read got=%b exp=0000", SRC_READ); end
      checks++; if (FIFO_DATA !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", FIFO_DATA); end
      checks++; if (GRANT_ID !== 3'd0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", GRANT_ID); end
   endtask

   task automatic test_single;
      int b;
      do_reset();
      b = popped[1];
      tot[1] = b + 5;
      FIFO_READ_NEXT = 1'b1;
      step();
      checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", BUSY); end
      checks++; if (GRANT_ID !== 3'd1) begin failures++; $display("FAIL single_grant got=%0d exp=1", GRANT_ID); end
      checks++; if (FIFO_EMPTY !== 1'b0) begin failures++; $display("FAIL single_latency empty got=%b exp=0", FIFO_EMPTY); end
      repeat (7) step();
      checks++; if (ps.size() != 5) begin failures++; $display("FAIL single_count got=%0d exp=5", ps.size()); end
      for (int k = 0; k < ps.size(); k++) begin
         checks++;
         if (ps[k] != 1 || pd[k] !== exp_word(1, b + k)) begin
            failures++;
            $display("FAIL single_word%0d got src=%0d data=%h exp src=1 data=%h", k, ps[k], pd[k], exp_word(1, b + k));
         end
      end
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL single_release busy got=%b exp=0", BUSY); end
      checks++; if (FIFO_EMPTY !== 1'b1) begin failures++; $display("FAIL single_idle_empty got=%b exp=1", FIFO_EMPTY); end
      checks++; if (GRANT_ID !== 3'd1) begin failures++; $display("FAIL single_grant_hold got=%0d exp=1", GRANT_ID); end
   endtask

   task automatic test_burst;
      int b0, b2, n0, n2, es, bad, first, last, idles, nopop;
      int exp_src[$];
      do_reset();
      b0 = popped[0];
      b2 = popped[2];
      tot[0] = b0 + 40;
      tot[2] = b2 + 40;
      FIFO_READ_NEXT = 1'b1;
      repeat (100) step();
      for (int r = 0; r < 6; r++)
         for (int k = 0; k < (r < 4 ? 16 : 8); k++) exp_src.push_back(r % 2 == 0 ? 0 : 2);
      checks++; if (ps.size() != 80) begin failures++; $display("FAIL burst_count got=%0d exp=80", ps.size()); end
      bad = 0; n0 = 0; n2 = 0;
      for (int k = 0; k < ps.size() && k < 80; k++) begin
         es = exp_src[k];
         if (ps[k] != es || pd[k] !== exp_word(es, es == 0 ? b0 + n0 : b2 + n2)) bad++;
         if (es == 0) n0++; else n2++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL burst_order bad_words got=%0d exp=0", bad); end
      first = -1; last = -1;
      for (int k = 0; k < ev.size(); k++)
         if (ev[k] < 8) begin
            if (first < 0) first = k;
            last = k;
         end
      idles = 0; nopop = 0;
      for (int k = first; k <= last && first >= 0; k++) begin
         if (ev[k] == 8) idles++;
         if (ev[k] == 9) nopop++;
      end
      checks++; if (idles != 5) begin failures++; $display("FAIL burst_idle_gaps got=%0d exp=5", idles); end
      checks++; if (nopop != 1) begin failures++; $display("FAIL burst_nopop got=%0d exp=1", nopop); end
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL burst_end_busy got=%b exp=0", BUSY); end
   endtask

   task automatic test_back_pressure;
      int b;
      do_reset();
      b = popped[2];
      tot[2] = b + 10;
      step();
      for (int i = 0; i < 4; i++) begin
         FIFO_READ_NEXT = (i == 0 || i == 3);
         #1;
         checks++;
         if (SRC_READ !== ((i == 0 || i == 3) ? 4'b0100 : 4'b0000)) begin
            failures++;
            $display("FAIL bp_read%0d got=%b exp=%b", i, SRC_READ, (i == 0 || i == 3) ? 4'b0100 : 4'b0000);
         end
         step();
      end
      FIFO_READ_NEXT = 1'b0;
      #1;
      checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL bp_busy got=%b exp=1", BUSY); end
      checks++; if (dut.burst_q !== 8'd2) begin failures++; $display("FAIL bp_burst_cnt got=%0d exp=2", dut.burst_q); end
      checks++; if (GRANT_ID !== 3'd2) begin failures++; $display("FAIL bp_grant got=%0d exp=2", GRANT_ID); end
      checks++; if (FIFO_DATA !== exp_word(2, b + 2)) begin failures++; $display("FAIL bp_data got=%h exp=%h", FIFO_DATA, exp_word(2, b + 2)); end
   endtask

   task automatic test_enable_drop;
      int b3;
      do_reset();
      SRC_ENABLE = 4'b1000;
      b3 = popped[3];
      tot[3] = b3 + 10;
      tot[1] = popped[1] + 10;
      step();
      checks++; if (GRANT_ID !== 3'd3) begin failures++; $display("FAIL drop_grant3 got=%0d exp=3", GRANT_ID); end
      SRC_ENABLE = 4'b1010;
      FIFO_READ_NEXT = 1'b1;
      step();
      step();
      SRC_ENABLE = 4'b0010;
      #1;
      checks++; if (SRC_READ !== 4'b1000) begin failures++; $display("FAIL drop_last_read got=%b exp=1000", SRC_READ); end
      checks++; if (FIFO_DATA !== exp_word(3, b3 + 2)) begin failures++; $display("FAIL drop_last_data got=%h exp=%h", FIFO_DATA, exp_word(3, b3 + 2)); end
      step();
      checks++; if (SRC_READ !== 4'b0000) begin failures++; $display("FAIL drop_no_read got=%b exp=0000", SRC_READ); end
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL drop_release got=%b exp=0", BUSY); end
      checks++; if (popped[3] - b3 != 3) begin failures++; $display("FAIL drop_pops got=%0d exp=3", popped[3] - b3); end
      step();
      checks++; if (GRANT_ID !== 3'd1) begin failures++; $display("FAIL drop_next_grant got=%0d exp=1", GRANT_ID); end
      checks++; if (SRC_READ !== 4'b0010) begin failures++; $display("FAIL drop_next_read got=%b exp=0010", SRC_READ); end
   endtask

   task automatic test_fairness;
      int ord[$];
      do_reset();
      for (int i = 0; i < 4; i++) tot[i] = popped[i] + 20;
      FIFO_READ_NEXT = 1'b1;
      repeat (110) step();
      for (int k = 0; k < ps.size(); k++)
         if (ord.size() == 0 || ord[ord.size()-1] != ps[k]) ord.push_back(ps[k]);
      checks++; if (ps.size() != 80) begin failures++; $display("FAIL fair_count got=%0d exp=80", ps.size()); end
      checks++; if (ord.size() != 8) begin failures++; $display("FAIL fair_bursts got=%0d exp=8", ord.size()); end
      for (int k = 0; k < ord.size() && k < 8; k++) begin
         checks++;
         if (ord[k] != k % 4) begin failures++; $display("FAIL fair_order%0d got=%0d exp=%0d", k, ord[k], k % 4); end
      end
      SRC_ENABLE = 4'b0000;
      for (int i = 0; i < 4; i++) tot[i] = popped[i] + 5;
      repeat (5) begin
         step();
         checks++;
         if (FIFO_EMPTY !== 1'b1 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL fair_disabled got empty=%b busy=%b exp empty=1 busy=0", FIFO_EMPTY, BUSY);
         end
      end
   endtask

   task automatic test_async_reset;
      int b;
      do_reset();
      b = popped[2];
      tot[2] = b + 10;
      FIFO_READ_NEXT = 1'b1;
      repeat (3) step();
      checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL ar_pre_busy got=%b exp=1", BUSY); end
      #2 RESET_N = 1'b0;
      #1;
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL ar_busy got=%b exp=0", BUSY); end
      checks++; if (FIFO_EMPTY !== 1'b1) begin failures++; $display("FAIL ar_empty got=%b exp=1", FIFO_EMPTY); end
      checks++; if (SRC_READ !== 4'b0) begin failures++; $display("FAIL ar_read got=%b exp=0000", SRC_READ); end
      checks++; if (FIFO_DATA !== 32'h0) begin failures++; $display("FAIL ar_data got=%h exp=0", FIFO_DATA); end
      checks++; if (GRANT_ID !== 3'd0) begin failures++; $display("FAIL ar_grant got=%0d exp=0", GRANT_ID); end
      tot[0] = popped[0] + 3;
      step();
      checks++; if (popped[2] - b != 2) begin failures++; $display("FAIL ar_pops got=%0d exp=2", popped[2] - b); end
      RESET_N = 1'b1;
      step();
      checks++; if (GRANT_ID !== 3'd0) begin failures++; $display("FAIL ar_restart_grant got=%0d exp=0", GRANT_ID); end
      checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL ar_restart_busy got=%b exp=1", BUSY); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_back_pressure();
      test_enable_drop();
      test_fairness();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
